// File: rtl/add_seq_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_BITS = 4;

    // Counter width for a given nibble count; never narrower than one bit.
    function automatic int cnt_width(input int nib);
        int w;
        w = $clog2(nib);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/add_4.sv
// 4-bit ripple adder used as the shared datapath of add_seq_ctrl.
module add_4 (
    output logic [3:0] s,
    output logic       co,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};

endmodule

// File: rtl/add_seq_ctrl.sv
// Nibble-serial adder: one shared add_4, LSB nibble first, valid/ready on both sides.
// Optional signed-overflow output enabled by defining ADD_SEQ_OVF_EN.
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef ADD_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB   = WIDTH / NIB_BITS;
    localparam int CNT_W = cnt_width(NIB);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               carry_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   s_reg;
    logic               co_reg;

    logic [NIB_BITS-1:0] a_nib [NIB];
    logic [NIB_BITS-1:0] b_nib [NIB];
    logic [NIB_BITS-1:0] sum_nib;
    logic                sum_co;

    // Split latched operands into nibbles so the counter selects one per cycle.
    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[gi*NIB_BITS +: NIB_BITS];
            assign b_nib[gi] = b_reg[gi*NIB_BITS +: NIB_BITS];
        end
    endgenerate

    add_4 u_add_4 (
        .s  (sum_nib),
        .co (sum_co),
        .a  (a_nib[cnt_reg]),
        .b  (b_nib[cnt_reg]),
        .ci (carry_reg)
    );

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign s         = s_reg;
    assign co        = co_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            co_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= ci;
                        cnt_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    // Only the current nibble is written; the rest keep their old value.
                    for (int i = 0; i < NIB; i++) begin
                        if (cnt_reg == CNT_W'(i)) begin
                            s_reg[i*NIB_BITS +: NIB_BITS] <= sum_nib;
                        end
                    end
                    carry_reg <= sum_co;
                    if (cnt_reg == LAST) begin
                        co_reg    <= sum_co;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef ADD_SEQ_OVF_EN
    logic ovf_reg;

    // The MSB of the sum is the one being produced on the final RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == RUN && cnt_reg == LAST) begin
            ovf_reg <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                       (sum_nib[NIB_BITS-1] != a_reg[WIDTH-1]);
        end else if (state_reg == DONE && out_ready) begin
            ovf_reg <= 1'b0;
        end
    end

    assign ovf = ovf_reg;
`endif

endmodule
